fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the write port of the dual-clock FIFO among NUM_REQ requesters in the write-clock domain. Grants are burst-locked: the owner keeps the port until its last word, MAX_BURST words, or withdrawal of its request. Sits directly in front of the FIFO write side and drives wr_en and din, respecting full.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 16, word width; must equal the FIFO data_width
MAX_BURST, 8, maximum words per grant (>=1)

Ports:
clk  in  1  write-domain clock (FIFO wr_clk)
rst  in  1  reset, synchronous, active-high
req  in  NUM_REQ  per-requester word-valid/request
req_last  in  NUM_REQ  marks the requester's current word as end of its burst
req_data  in  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ack  out  NUM_REQ  word of requester i accepted this cycle
grant  out  NUM_REQ  one-hot current owner, registered; 0 when idle
fifo_wr_en  out  1  to FIFO wr_en
fifo_din  out  DATA_WIDTH  to FIFO din
fifo_full  in  1  from FIFO full
busy  out  1  state is BURST
burst_done  out  1  one-cycle pulse, registered, cycle after a burst terminates

Behaviour:
- One clock; reset is synchronous and active-high: clk and rst.
- Reset values: state IDLE, grant=0, busy=0, burst_done=0, beat counter=0, rr pointer=NUM_REQ-1, so requester 0 has top priority first. fifo_wr_en and req_ack are 0 during and after reset until a grant exists.
- States: IDLE, BURST.
- IDLE: if any req bit is set, pick the first set bit searching from (ptr+1) mod NUM_REQ upward with wrap. Register grant one-hot and owner index, counter=0, go to BURST. Arbitration latency is 1 cycle: the first word can be accepted in the cycle after grant is chosen. No req: stay IDLE, grant=0.
- BURST, combinational: fifo_wr_en = req[owner] & ~fifo_full. req_ack[owner] = fifo_wr_en, and all other req_ack bits are 0. fifo_din = owner slice of req_data. When fifo_wr_en=0, fifo_din holds the owner slice anyway (don't-care to FIFO).
- Accepted beat (fifo_wr_en=1): counter += 1. Counter width is clog2(MAX_BURST)+1.
- Termination, checked each BURST cycle in this priority order:
  (a) accepted beat with req_last[owner]=1;
  (b) accepted beat with counter==MAX_BURST-1 (MAX_BURST-th word);
  (c) req[owner]=0, which is a withdrawal: no beat, burst aborted.
  On any termination: ptr<=owner, grant<=0, state<=IDLE, burst_done<=1 for the next cycle only.
- One IDLE cycle always separates consecutive bursts, including the same requester re-winning.
- fifo_full=1 in BURST: no ack, counter frozen, grant held indefinitely. Withdrawal (c) still terminates while full.
- req_last on a non-accepted cycle (full or req low) has no effect.
- MAX_BURST=1: every burst is exactly one word; pure word-level round-robin with an idle cycle between.
- Non-owner req bits are ignored in BURST and may toggle freely.
- Requesters must hold req_data/req_last stable while req=1 and no ack.
- rst asserted mid-burst: next edge returns to reset values. A word acked in that same cycle is already written to the FIFO, and no further words are written.
- All outputs except req_ack, fifo_wr_en and fifo_din are registered.

Test Plan:
- Reset then req=4'b0001, data 0x1000..0x1003, last on 4th word, full=0 -> grant=0001 one cycle after req, fifo_wr_en high 4 consecutive cycles writing 0x1000..0x1003, burst_done pulse next cycle, grant=0.
- req=4'b1111 constant, no last, MAX_BURST=8 -> grants in order 0,1,2,3,0 with exactly 8 writes per grant and one idle cycle between grants; 33 writes after 4 bursts + 1.
- Owner 2 mid-burst after 3 words, fifo_full high for 5 cycles -> no fifo_wr_en/req_ack for those 5 cycles, counter stays 3, burst resumes and ends after 5 more words (total 8).
- Owner 1 drops req after 2 words with req=4'b1010 -> burst_done pulse, next grant=1000 (requester 3), not requester 1.
- rst pulsed for 1 cycle during a burst of requester 3 -> grant=0 and busy=0 next cycle; with req=1111 afterwards, first grant=0001.
- MAX_BURST=1 build, req=4'b0101 -> alternating single writes from 0 and 2, each followed by an idle cycle; req_ack never two bits set at once.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one FIFO write port among NUM_REQ
// requesters; owner keeps the port until last word, MAX_BURST words or withdrawal.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    input  logic                          fifo_full,
    output logic                          busy,
    output logic                          burst_done
);

    localparam int          IDX_W     = $clog2(NUM_REQ);
    localparam int          CNT_W     = $clog2(MAX_BURST) + 1;
    localparam int unsigned NR        = NUM_REQ;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand;
    logic                 owner_req;
    logic                 owner_last;

    // Search starts one past the previous owner and wraps.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= NR; i++) begin
            cand = IDX_W'((32'(ptr_q) + i) % NR);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        owner_req  = req[owner_q];
        owner_last = req_last[owner_q];
        fifo_din   = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
        fifo_wr_en = (state_q == BURST) && owner_req && !fifo_full;
        req_ack    = fifo_wr_en ? grant_q : '0;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_found) begin
                    grant_d = NUM_REQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                // Termination priority: last word, beat limit, then withdrawal.
                if (fifo_wr_en) begin
                    cnt_d = cnt_q + 1'b1;
                    if (owner_last || cnt_q == LAST_BEAT) begin
                        ptr_d   = owner_q;
                        grant_d = '0;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (!owner_req) begin
                    ptr_d   = owner_q;
                    grant_d = '0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = (state_q == BURST);
    assign burst_done = done_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: MAX_BURST=8 and MAX_BURST=1 builds on shared stimulus,
// checked every cycle against a transaction-level model plus directed literals.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic            fifo_full = 1'b0;

    logic [N-1:0]  ack0, ack1, grant0, grant1;
    logic          wr0, wr1, busy0, busy1, done0, done1;
    logic [DW-1:0] din0, din1;

    int nword   [N];
    int last_at [N];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Requester i offers 0x1000*(i+1)+k as its k-th word; last flagged on word last_at[i].
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = DW'(32'h1000 * (i + 1) + nword[i]);
            req_last[i]          = (last_at[i] != 0) && (nword[i] == last_at[i] - 1);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) nword[i] <= 0;
            else if (ack0[i]) nword[i] <= nword[i] + 1;
        end
    end

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(8)) dut0 (
        .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_data(req_data),
        .req_ack(ack0), .grant(grant0), .fifo_wr_en(wr0), .fifo_din(din0),
        .fifo_full(fifo_full), .busy(busy0), .burst_done(done0)
    );

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_data(req_data),
        .req_ack(ack1), .grant(grant1), .fifo_wr_en(wr1), .fifo_din(din1),
        .fifo_full(fifo_full), .busy(busy1), .burst_done(done1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model: owner (-1 = none), words taken, last owner
    int  m_own  [2];
    int  m_cnt  [2];
    int  m_ptr  [2];
    bit  m_done [2];
    int  mb     [2] = '{8, 1};
    bit  armed = 1'b0;

    always @(posedge clk) begin
        int  o, idx;
        bit  fin;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_own[k]  = -1;
                m_cnt[k]  = 0;
                m_ptr[k]  = N - 1;
                m_done[k] = 1'b0;
            end else begin
                m_done[k] = 1'b0;
                if (m_own[k] < 0) begin
                    for (int j = 1; j <= N; j++) begin
                        idx = (m_ptr[k] + j) % N;
                        if (m_own[k] < 0 && req[idx]) m_own[k] = idx;
                    end
                    m_cnt[k] = 0;
                end else begin
                    o   = m_own[k];
                    fin = 1'b0;
                    if (req[o] && !fifo_full) begin
                        m_cnt[k] = m_cnt[k] + 1;
                        if (req_last[o] || m_cnt[k] == mb[k]) fin = 1'b1;
                    end else if (!req[o]) begin
                        fin = 1'b1;
                    end
                    if (fin) begin
                        m_ptr[k]  = o;
                        m_own[k]  = -1;
                        m_done[k] = 1'b1;
                    end
                end
            end
        end
        if (rst) armed = 1'b1;
    end

    always @(negedge clk) begin
        int            own;
        logic [N-1:0]  eg, ea, ag, aa;
        logic          ew, aw, ab, ad;
        logic [DW-1:0] adin;
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                own  = m_own[k];
                eg   = (own < 0) ? '0 : (N'(1) << own);
                ew   = (own >= 0) && req[own] && !fifo_full;
                ea   = ew ? eg : '0;
                ag   = k ? grant1 : grant0;
                aa   = k ? ack1   : ack0;
                aw   = k ? wr1    : wr0;
                ab   = k ? busy1  : busy0;
                ad   = k ? done1  : done0;
                adin = k ? din1   : din0;
                chk($sformatf("dut%0d.grant", k), 64'(ag), 64'(eg));
                chk($sformatf("dut%0d.busy", k), 64'(ab), 64'(own >= 0));
                chk($sformatf("dut%0d.burst_done", k), 64'(ad), 64'(m_done[k]));
                chk($sformatf("dut%0d.fifo_wr_en", k), 64'(aw), 64'(ew));
                chk($sformatf("dut%0d.req_ack", k), 64'(aa), 64'(ea));
                if (ew) chk($sformatf("dut%0d.fifo_din", k), 64'(adin), 64'(req_data[own*DW +: DW]));
            end
        end
    end

    // ---------------- write logs (owner, data, cycle) for directed checks
    typedef struct {
        int            own;
        logic [DW-1:0] d;
        int            cyc;
    } wr_t;

    wr_t log0[$];
    wr_t log1[$];
    int  cyc = 0;

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge clk) begin
        wr_t e;
        cyc++;
        if (wr0) begin
            e.own = oh_idx(ack0); e.d = din0; e.cyc = cyc;
            log0.push_back(e);
        end
        if (wr1) begin
            e.own = oh_idx(ack1); e.d = din1; e.cyc = cyc;
            log1.push_back(e);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) last_at[i] = 0;
        step(1);
        rst = 1'b0;
        log0.delete();
        log1.delete();
    endtask

    initial begin
        int bad;
        for (int i = 0; i < N; i++) last_at[i] = 0;

        // Reset state, then a single 4-word burst from requester 0.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        log0.delete();
        log1.delete();
        chk("rst_grant", 64'(grant0), 64'h0);
        chk("rst_busy", 64'(busy0), 64'h0);
        chk("rst_wr_en", 64'(wr0), 64'h0);
        chk("rst_ack", 64'(ack0), 64'h0);
        last_at[0] = 4;
        req = 4'b0001;
        step(1);
        chk("p1_grant", 64'(grant0), 64'h1);
        step(4);
        chk("p1_done", 64'(done0), 64'h1);
        chk("p1_grant_off", 64'(grant0), 64'h0);
        req = '0;
        chk("p1_nwrites", 64'(log0.size()), 64'd4);
        bad = 0;
        for (int i = 0; i < log0.size() && i < 4; i++)
            if (log0[i].d !== DW'(16'h1000 + i) || log0[i].cyc != log0[0].cyc + i) bad++;
        chk("p1_data", 64'(bad), 64'd0);
        step(1);
        chk("p1_done_pulse", 64'(done0), 64'h0);

        // All four requesting, no last: 8-word bursts in order 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        step(38);
        chk("p2_nwrites", 64'(log0.size()), 64'd33);
        bad = 0;
        for (int i = 0; i < log0.size() && i < 33; i++)
            if (log0[i].own != (i / 8) % 4) bad++;
        chk("p2_order", 64'(bad), 64'd0);
        if (log0.size() >= 9) chk("p2_gap", 64'(log0[8].cyc - log0[7].cyc), 64'd2);
        else chk("p2_gap", 64'(log0.size()), 64'd9);
        req = '0;
        step(2);

        // Requester 2 stalled by full for 5 cycles after 3 words.
        do_reset();
        req = 4'b0100;
        step(1);
        chk("p3_grant", 64'(grant0), 64'h4);
        step(3);
        chk("p3_before_full", 64'(log0.size()), 64'd3);
        fifo_full = 1'b1;
        step(5);
        chk("p3_during_full", 64'(log0.size()), 64'd3);
        chk("p3_grant_held", 64'(grant0), 64'h4);
        fifo_full = 1'b0;
        step(5);
        chk("p3_total", 64'(log0.size()), 64'd8);
        chk("p3_done", 64'(done0), 64'h1);
        req = '0;
        step(2);

        // Requester 1 withdraws after 2 words; requester 3 wins next.
        do_reset();
        req = 4'b1010;
        step(1);
        chk("p4_grant1", 64'(grant0), 64'h2);
        step(2);
        chk("p4_words", 64'(log0.size()), 64'd2);
        req = 4'b1000;
        step(1);
        chk("p4_done", 64'(done0), 64'h1);
        step(1);
        chk("p4_grant3", 64'(grant0), 64'h8);
        req = '0;
        step(2);

        // Reset pulsed during requester 3's burst.
        do_reset();
        req = 4'b1000;
        step(2);
        chk("p5_words", 64'(log0.size()), 64'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("p5_word_in_rst", 64'(log0.size()), 64'd2);
        chk("p5_grant", 64'(grant0), 64'h0);
        chk("p5_busy", 64'(busy0), 64'h0);
        req = 4'b1111;
        step(1);
        chk("p5_regrant", 64'(grant0), 64'h1);
        req = '0;
        step(2);

        // MAX_BURST=1 build: alternating single words from 0 and 2.
        do_reset();
        req = 4'b0101;
        step(8);
        chk("p6_nwrites", 64'(log1.size()), 64'd4);
        bad = 0;
        for (int i = 0; i < log1.size() && i < 4; i++) begin
            if (log1[i].own != ((i % 2) ? 2 : 0)) bad++;
            if (i > 0 && log1[i].cyc - log1[i-1].cyc != 2) bad++;
        end
        chk("p6_pattern", 64'(bad), 64'd0);
        req = '0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
